i2c_slave_regs: RTL
===================

# i2c_slave_regs

I2C target (slave) endpoint that sits directly downstream of the team's `i2c_master` on the same two-wire bus. It oversamples SCL/SDA on the system clock and detects START, repeated START and STOP. It matches a 7-bit device address, accepts up to 4 written bytes into a 32-bit word, and returns a 32-bit word on reads. Byte order is MSB-first, with byte 0 = bits [31:24], matching the master's Din/Dout packing.

## Interface
- `DEV_ADDR`, 7'h50, 7-bit address this target answers to.
- `clk`  input  1  system clock; must be at least 8x the SCL rate.
- `rst`  input  1  reset; asynchronous, active-low.
- `i2c_scl`  input  1  bus clock; the block never stretches SCL.
- `i2c_sda`  inout  1  bus data; the block only drives 0 or releases it (1'bz).
- `tx_data`  input  32  read data; captured at the address-ACK of a read.
- `rx_data`  output  32  last committed write data; unwritten bytes are 0.
- `rx_count`  output  3  number of bytes in the last committed write (0–4).
- `rx_valid`  output  1  one-cycle pulse when a write is committed.
- `busy`  output  1  high from address match until STOP, or until START/repeated START re-enters ADDR.
- `istate`  output  3  current FSM state, for debug.

## Operation
- **Input conditioning:** SCL and SDA pass through 2-FF synchronizers, then a 1-FF delay. Edges are taken from the synchronized/delayed pair.
- **START:** SDA falls while SCL is high.
- **STOP:** SDA rises while SCL is high.
- **Bit sampling:** on SCL rising edge.
- **SDA drive changes:** only on SCL falling edge.
- **FSM states:** IDLE=0, ADDR=1, ADDR_ACK=2, WR_BYTE=3, WR_ACK=4, RD_BYTE=5, RD_ACK=6, WAIT_STOP=7.
- **From any state:**
  - START → ADDR, with bit counter = 0.
  - STOP → IDLE.
  - Before changing state on START or STOP, any pending write with at least 1 byte is committed.
- **ADDR:**
  - Shift in 8 bits (7 address bits, then R/W).
  - Address match → ADDR_ACK.
  - Mismatch → WAIT_STOP, with SDA released.
- **ADDR_ACK:**
  - Drive SDA low from the falling edge after bit 8 until the next falling edge.
  - Write: → WR_BYTE; clear the shadow buffer and byte index.
  - Read: latch `tx_data`, load the shift register with byte 0, drive its MSB on that same falling edge, → RD_BYTE.
- **WR_BYTE:**
  - Shift in 8 bits.
  - Byte index < 4: store into shadow[31-8k -: 8], → WR_ACK with ACK driven.
  - 5th and later bytes: SDA stays released (NACK), byte discarded, → WAIT_STOP.
- **WR_ACK:** release on the next falling edge, increment index, → WR_BYTE.
- **RD_BYTE:**
  - Present the next bit on each falling edge.
  - After 8 bits, release SDA on the falling edge → RD_ACK.
- **RD_ACK:**
  - Sample SDA on the rising edge.
  - 0 (ACK) → load next byte, → RD_BYTE.
  - 1 (NACK) → WAIT_STOP.
  - Bytes past index 3 read as 8'hFF.
- **WAIT_STOP:** SDA released; wait for START or STOP.
- **Commit:** `rx_data` ← shadow (unwritten bytes 0), `rx_count` ← bytes written, `rx_valid` = 1 for exactly one clk.
  - A write with 0 data bytes does not commit.
  - NACKed overflow bytes are not counted.

## Timing
- **Reset values:** state IDLE; SDA released; `rx_data` = 0; `rx_count` = 0; `rx_valid` = 0; `busy` = 0; `istate` = 0.
- **Pin-to-internal latency:** 3 clk from a pin edge to its internal edge event.
- **SDA drive latency:** SDA drive/release occurs 3–4 clk after the SCL falling pin edge. This is within the low phase, given clk ≥ 8x SCL.
- **`rx_valid`:** asserts 4 clk after the STOP or repeated-START pin event.
- **Read capture:** `tx_data` is sampled once per read transaction. Changes afterwards do not affect that transaction.
- **Simultaneous events:** START/STOP detection takes priority over the SCL-edge action in the same cycle.
- **Async reset:** asserting `rst` mid-transfer releases SDA immediately (combinationally). No commit occurs.
- **After reset release:** the block ignores the bus until the next START.

## Test plan
- Write to 0x50 with bytes DE AD BE EF, then STOP → SDA low in all 5 ACK slots; `rx_data` = 32'hDEADBEEF; `rx_count` = 4; one `rx_valid` pulse.
- Read from 0x50 with `tx_data` = 32'h12345678; master ACKs 3 bytes and NACKs the 4th → bus bytes 12 34 56 78; SDA released after the NACK; `busy` = 0 after STOP.
- Address 0x51 write → SDA never driven low; no `rx_valid`; `istate` = 7 until STOP.
- Write of A5 5A, then repeated START and a read of 0x50 → commit `rx_data` = 32'hA55A0000, `rx_count` = 2 at the repeated START; read returns `tx_data` bytes.
- 5-byte write 01 02 03 04 05 → 5th byte NACKed; `rx_data` = 32'h01020304; `rx_count` = 4.
- `rst` low during a read data bit → SDA is z in the same cycle; `istate` = 0; no `rx_valid`; the next full write works normally.

Source files
------------

// File: rtl/i2c_slave_regs.sv
// I2C target endpoint: oversampled SCL/SDA, 7-bit address match,
// up to 4 write bytes into a 32-bit word, 32-bit word returned on reads.
`timescale 1ns/1ps
module i2c_slave_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i2c_scl,
    inout  wire         i2c_sda,
    input  logic [31:0] tx_data,
    output logic [31:0] rx_data,
    output logic [2:0]  rx_count,
    output logic        rx_valid,
    output logic        busy,
    output logic [2:0]  istate
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WR_BYTE   = 3'd3,
        WR_ACK    = 3'd4,
        RD_BYTE   = 3'd5,
        RD_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    // [0],[1] synchronizer, [2] one-clk delay for edge detection
    logic [2:0] scl_p;
    logic [2:0] sda_p;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_p <= 3'b111;
            sda_p <= 3'b111;
        end else begin
            scl_p <= {scl_p[1:0], i2c_scl};
            sda_p <= {sda_p[1:0], i2c_sda};
        end
    end

    logic scl_rise, scl_fall, start_ev, stop_ev, sda_in;

    assign scl_rise = scl_p[1] & ~scl_p[2];
    assign scl_fall = ~scl_p[1] & scl_p[2];
    assign start_ev = scl_p[1] & scl_p[2] & sda_p[2] & ~sda_p[1];
    assign stop_ev  = scl_p[1] & scl_p[2] & ~sda_p[2] & sda_p[1];
    assign sda_in   = sda_p[1];

    state_t      state, state_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [7:0]  shift, shift_n;
    logic [31:0] shadow, shadow_n;
    logic [2:0]  byte_idx, idx_n;
    logic        sda_oe, oe_n;
    logic [31:0] tx_word, txw_n;
    logic [31:0] rxd_n;
    logic [2:0]  rxc_n;
    logic        rxv_n;
    logic        busy_n;
    logic        wr_act, wr_n;
    logic        rd_mode, rd_n;
    logic [7:0]  rd_next;

    always_comb begin
        case (byte_idx)
            3'd0:    rd_next = tx_word[31:24];
            3'd1:    rd_next = tx_word[23:16];
            3'd2:    rd_next = tx_word[15:8];
            3'd3:    rd_next = tx_word[7:0];
            default: rd_next = 8'hFF;
        endcase
    end

    always_comb begin
        state_n  = state;
        bit_n    = bit_cnt;
        shift_n  = shift;
        shadow_n = shadow;
        idx_n    = byte_idx;
        oe_n     = sda_oe;
        txw_n    = tx_word;
        rxd_n    = rx_data;
        rxc_n    = rx_count;
        rxv_n    = 1'b0;
        busy_n   = busy;
        wr_n     = wr_act;
        rd_n     = rd_mode;
        if (start_ev || stop_ev) begin
            if (wr_act && byte_idx != 3'd0) begin
                rxd_n = shadow;
                rxc_n = byte_idx;
                rxv_n = 1'b1;
            end
            state_n = start_ev ? ADDR : IDLE;
            bit_n   = 3'd0;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            wr_n    = 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda_in};
                        bit_n   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rd_n = sda_in;
                            if (shift[6:0] == DEV_ADDR) begin
                                state_n = ADDR_ACK;
                                busy_n  = 1'b1;
                            end else begin
                                state_n = WAIT_STOP;
                            end
                        end
                    end
                end
                // first fall drives the ACK, second fall ends it
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            oe_n = 1'b1;
                        end else if (rd_mode) begin
                            txw_n   = tx_data;
                            shift_n = tx_data[31:24];
                            oe_n    = ~tx_data[31];
                            bit_n   = 3'd0;
                            idx_n   = 3'd0;
                            state_n = RD_BYTE;
                        end else begin
                            oe_n     = 1'b0;
                            shadow_n = 32'd0;
                            idx_n    = 3'd0;
                            bit_n    = 3'd0;
                            wr_n     = 1'b1;
                            state_n  = WR_BYTE;
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda_in};
                        bit_n   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_idx < 3'd4) begin
                                case (byte_idx[1:0])
                                    2'd0: shadow_n[31:24] = {shift[6:0], sda_in};
                                    2'd1: shadow_n[23:16] = {shift[6:0], sda_in};
                                    2'd2: shadow_n[15:8]  = {shift[6:0], sda_in};
                                    2'd3: shadow_n[7:0]   = {shift[6:0], sda_in};
                                endcase
                                idx_n   = byte_idx + 3'd1;
                                state_n = WR_ACK;
                            end else begin
                                state_n = WAIT_STOP;
                            end
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            oe_n = 1'b1;
                        end else begin
                            oe_n    = 1'b0;
                            bit_n   = 3'd0;
                            state_n = WR_BYTE;
                        end
                    end
                end
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            oe_n    = 1'b0;
                            bit_n   = 3'd0;
                            state_n = RD_ACK;
                        end else begin
                            shift_n = {shift[6:0], 1'b0};
                            oe_n    = ~shift[6];
                            bit_n   = bit_cnt + 3'd1;
                        end
                    end
                end
                // bit_cnt==1 marks that the master ACKed this slot
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_in) begin
                            state_n = WAIT_STOP;
                        end else begin
                            bit_n = 3'd1;
                            if (byte_idx < 3'd4)
                                idx_n = byte_idx + 3'd1;
                        end
                    end else if (scl_fall && bit_cnt == 3'd1) begin
                        shift_n = rd_next;
                        oe_n    = ~rd_next[7];
                        bit_n   = 3'd0;
                        state_n = RD_BYTE;
                    end
                end
                WAIT_STOP: oe_n = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
            shadow   <= 32'd0;
            byte_idx <= 3'd0;
            sda_oe   <= 1'b0;
            tx_word  <= 32'd0;
            rx_data  <= 32'd0;
            rx_count <= 3'd0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            wr_act   <= 1'b0;
            rd_mode  <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            shadow   <= shadow_n;
            byte_idx <= idx_n;
            sda_oe   <= oe_n;
            tx_word  <= txw_n;
            rx_data  <= rxd_n;
            rx_count <= rxc_n;
            rx_valid <= rxv_n;
            busy     <= busy_n;
            wr_act   <= wr_n;
            rd_mode  <= rd_n;
        end
    end

    // gated with rst so a mid-transfer reset frees the bus at once
    assign i2c_sda = (sda_oe && rst) ? 1'b0 : 1'bz;
    assign istate  = state;

endmodule
